serial2parallel: RTL and testbench

SERIAL2PARALLEL -- requirements
Module: serial2parallel

---
 rtl/s2p_pkg.sv | 11 +
 rtl/serial2parallel.sv | 114 +++++++++++
 tb/tb_serial2parallel.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/s2p_pkg.sv
// Shared types and defaults for the serial-to-parallel frame receiver.
package s2p_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } s2p_state_e;

  localparam int S2P_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial2parallel.sv
// Framed LSB-first serial receiver with a one-word valid/ready output buffer
// and registered frame_err / overrun pulses.
module serial2parallel
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  input  logic             serial_start,
  input  logic             serial_end,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  s2p_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] sr, sr_nxt, word;
  logic             complete, ferr_nxt;

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    sr_nxt          = sr;
    complete        = 1'b0;
    ferr_nxt        = 1'b0;
    word            = sr;
    word[WIDTH-1]   = d;

    case (state)
      IDLE: begin
        if (serial_start) begin
          if (serial_end) begin
            ferr_nxt = 1'b1;
          end else begin
            sr_nxt[0] = d;
            cnt_nxt   = ONE;
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        // A fresh start always wins: drop the partial frame and begin again.
        if (serial_start) begin
          ferr_nxt  = 1'b1;
          sr_nxt[0] = d;
          cnt_nxt   = ONE;
        end else if (cnt == LAST) begin
          if (serial_end) begin
            complete = 1'b1;
            sr_nxt   = word;
          end else begin
            ferr_nxt = 1'b1;
          end
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (serial_end) begin
          ferr_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          sr_nxt[cnt] = d;
          cnt_nxt     = cnt + ONE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
    end
  end

  // Output buffer: a completed word only lands if the slot is free or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_nxt;
      overrun   <= 1'b0;
      if (complete && (!q_valid || q_ready)) begin
        q       <= word;
        q_valid <= 1'b1;
      end else if (complete) begin
        overrun <= 1'b1;
      end else if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial2parallel.sv
// Directed bench for serial2parallel: scoreboard of expected words plus pulse checks.
module tb_serial2parallel;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         d = 1'b0;
  logic         serial_start = 1'b0;
  logic         serial_end = 1'b0;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ready = 1'b0;
  logic         frame_err;
  logic         overrun;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int ferr_base, ovr_base;
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_w;

  serial2parallel #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .serial_start(serial_start),
    .serial_end(serial_end), .q(q), .q_valid(q_valid), .q_ready(q_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun)   ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one serial cycle, then sample 1 time unit after the rising edge.
  task automatic step(input logic b, input logic s, input logic e);
    d = b; serial_start = s; serial_end = e;
    @(posedge clk);
    #1;
    d = 1'b0; serial_start = 1'b0; serial_end = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) step(w[i], i == 0, i == W - 1);
  endtask

  task automatic check_word(input string tag);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp_w = sb.pop_front();
      chk({tag, "_valid"}, 32'(q_valid), 32'd1);
      chk({tag, "_q"}, 32'(q), 32'(exp_w));
    end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_valid", 32'(q_valid), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // nominal frame, consumer always ready
    ferr_base = ferr_cnt; ovr_base = ovr_cnt;
    q_ready = 1'b1;
    sb.push_back(8'hD3);
    send_frame(8'hD3);
    check_word("nominal");
    step(1'b0, 1'b0, 1'b0);
    chk("nominal_drained", 32'(q_valid), 32'd0);
    chk("nominal_q_kept", 32'(q), 32'hD3);
    chk("nominal_no_err", 32'(ferr_cnt - ferr_base), 32'd0);
    chk("nominal_no_ovr", 32'(ovr_cnt - ovr_base), 32'd0);

    // back-to-back with stalled consumer: second word overruns
    q_ready = 1'b0;
    ovr_base = ovr_cnt;
    sb.push_back(8'hD3);
    send_frame(8'hD3);
    chk("b2b_first_valid", 32'(q_valid), 32'd1);
    send_frame(8'h5A);
    check_word("b2b_hold");
    chk("b2b_ovr_pulse", 32'(overrun), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("b2b_ovr_once", 32'(ovr_cnt - ovr_base), 32'd1);
    chk("b2b_ovr_low", 32'(overrun), 32'd0);
    chk("b2b_q_stable", 32'(q), 32'hD3);
    q_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    q_ready = 1'b0;
    chk("b2b_drained", 32'(q_valid), 32'd0);

    // early end on the 4th bit, then a good frame
    ferr_base = ferr_cnt;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("early_ferr", 32'(frame_err), 32'd1);
    chk("early_no_word", 32'(q_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("early_ferr_once", 32'(ferr_cnt - ferr_base), 32'd1);
    sb.push_back(8'hFF);
    send_frame(8'hFF);
    check_word("early_next");
    q_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    q_ready = 1'b0;

    // missing end: 8 bits with serial_end never asserted
    ferr_base = ferr_cnt;
    for (int i = 0; i < W; i++) step(1'b1, i == 0, 1'b0);
    chk("noend_ferr", 32'(frame_err), 32'd1);
    chk("noend_no_word", 32'(q_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("noend_ferr_once", 32'(ferr_cnt - ferr_base), 32'd1);
    chk("noend_idle_no_word", 32'(q_valid), 32'd0);

    // restart at bit 3 with a full frame
    ferr_base = ferr_cnt;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    sb.push_back(8'h81);
    send_frame(8'h81);
    check_word("restart");
    chk("restart_ferr_once", 32'(ferr_cnt - ferr_base), 32'd1);

    // reset in the middle of a frame (q_valid still high from the restart frame)
    ferr_base = ferr_cnt;
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_q", 32'(q), 32'd0);
    chk("midrst_valid", 32'(q_valid), 32'd0);
    chk("midrst_ferr", 32'(frame_err), 32'd0);
    chk("midrst_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b1);
    chk("midrst_ignored_end", 32'(frame_err), 32'd0);
    sb.push_back(8'h3C);
    send_frame(8'h3C);
    check_word("midrst_next");
    chk("midrst_no_err", 32'(ferr_cnt - ferr_base), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
